// File: rtl/rob_pkg.sv
// Shared types and widths for the 2-wide reorder buffer.
package rob_pkg;
  localparam int PR_TAG_W      = 7;
  localparam int AR_W          = 5;
  localparam int DEF_ROB_SIZE  = 32;
  localparam int DEF_ROB_IDX_W = 5;

  localparam logic [PR_TAG_W-1:0] NULL_TAG = 7'd0;

  typedef struct packed {
    logic                valid;
    logic                complete;
    logic [PR_TAG_W-1:0] pr;
    logic [PR_TAG_W-1:0] old_pr;
    logic [AR_W-1:0]     ar;
  } rob_entry_t;
endpackage

// File: rtl/rob_complete_cam.sv
// Matches both CDB tags against every waiting ROB entry.
module rob_complete_cam
  import rob_pkg::*;
#(
  parameter int ROB_SIZE = DEF_ROB_SIZE
) (
  input  logic [ROB_SIZE-1:0][PR_TAG_W-1:0] pr,
  input  logic [ROB_SIZE-1:0]               valid,
  input  logic [ROB_SIZE-1:0]               complete,
  input  logic                              cdb_valid_0,
  input  logic [PR_TAG_W-1:0]               cdb_tag_0,
  input  logic                              cdb_valid_1,
  input  logic [PR_TAG_W-1:0]               cdb_tag_1,
  output logic [ROB_SIZE-1:0]               set_complete
);
  always_comb begin
    set_complete = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      set_complete[i] = valid[i] & ~complete[i] &
        ((cdb_valid_0 & (pr[i] == cdb_tag_0)) |
         (cdb_valid_1 & (pr[i] == cdb_tag_1)));
    end
  end
endmodule

// File: rtl/rob.sv
// 2-wide in-order reorder buffer with CDB completion.
// Optional ROB_FLUSH_EN adds a rob_flush port that empties the buffer.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE  = DEF_ROB_SIZE,
  parameter int ROB_IDX_W = DEF_ROB_IDX_W
) (
  input  logic                clock,
  input  logic                reset,
`ifdef ROB_FLUSH_EN
  input  logic                rob_flush,
`endif
  input  logic [1:0]          id_dispatch_num,
  input  logic [PR_TAG_W-1:0] fl_rob_pr0,
  input  logic [PR_TAG_W-1:0] fl_rob_pr1,
  input  logic [PR_TAG_W-1:0] mt_rob_old_pr0,
  input  logic [PR_TAG_W-1:0] mt_rob_old_pr1,
  input  logic [AR_W-1:0]     id_rob_ar0,
  input  logic [AR_W-1:0]     id_rob_ar1,
  input  logic                cdb_valid_0,
  input  logic                cdb_valid_1,
  input  logic [PR_TAG_W-1:0] cdb_tag_0,
  input  logic [PR_TAG_W-1:0] cdb_tag_1,
  output logic [1:0]          rob_free_num,
  output logic [1:0]          rob_retire_num,
  output logic [PR_TAG_W-1:0] rob_retire_tag_0,
  output logic [PR_TAG_W-1:0] rob_retire_tag_1,
  output logic [PR_TAG_W-1:0] rob_retire_pr_0,
  output logic [PR_TAG_W-1:0] rob_retire_pr_1,
  output logic [AR_W-1:0]     rob_retire_ar_0,
  output logic [AR_W-1:0]     rob_retire_ar_1
);
  rob_entry_t ent [ROB_SIZE];

  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic [ROB_IDX_W:0]   count;
  logic [ROB_IDX_W-1:0] head1;
  logic [ROB_IDX_W-1:0] tail1;
  logic [ROB_IDX_W:0]   room;
  logic [1:0]           disp;
  logic [1:0]           acc;
  logic                 ret0;
  logic                 ret1;

  logic [ROB_SIZE-1:0][PR_TAG_W-1:0] pr_vec;
  logic [ROB_SIZE-1:0]               valid_vec;
  logic [ROB_SIZE-1:0]               complete_vec;
  logic [ROB_SIZE-1:0]               set_complete;

  always_comb begin
    pr_vec       = '0;
    valid_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      pr_vec[i]       = ent[i].pr;
      valid_vec[i]    = ent[i].valid;
      complete_vec[i] = ent[i].complete;
    end
  end

  rob_complete_cam #(
    .ROB_SIZE(ROB_SIZE)
  ) u_cam (
    .pr          (pr_vec),
    .valid       (valid_vec),
    .complete    (complete_vec),
    .cdb_valid_0 (cdb_valid_0),
    .cdb_tag_0   (cdb_tag_0),
    .cdb_valid_1 (cdb_valid_1),
    .cdb_tag_1   (cdb_tag_1),
    .set_complete(set_complete)
  );

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;

  // Free space uses the pre-retire count, so a full ROB never accepts.
  assign room = (ROB_IDX_W+1)'(ROB_SIZE) - count;
  assign rob_free_num = (room >= 2) ? 2'd2 : room[1:0];

  assign disp = (id_dispatch_num == 2'd3) ? 2'd2 : id_dispatch_num;
  assign acc  = (disp > rob_free_num) ? rob_free_num : disp;

  assign ret0 = ent[head].valid & ent[head].complete;
  assign ret1 = ret0 & ent[head1].valid & ent[head1].complete;

  assign rob_retire_num   = ret1 ? 2'd2 : (ret0 ? 2'd1 : 2'd0);
  assign rob_retire_tag_0 = ret0 ? ent[head].old_pr  : NULL_TAG;
  assign rob_retire_pr_0  = ret0 ? ent[head].pr      : NULL_TAG;
  assign rob_retire_ar_0  = ret0 ? ent[head].ar      : '0;
  assign rob_retire_tag_1 = ret1 ? ent[head1].old_pr : NULL_TAG;
  assign rob_retire_pr_1  = ret1 ? ent[head1].pr     : NULL_TAG;
  assign rob_retire_ar_1  = ret1 ? ent[head1].ar     : '0;

  always_ff @(posedge clock) begin
`ifdef ROB_FLUSH_EN
    if (reset || rob_flush) begin
`else
    if (reset) begin
`endif
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent[i].valid    <= 1'b0;
        ent[i].complete <= 1'b0;
      end
    end else begin
      head  <= head + ROB_IDX_W'(rob_retire_num);
      tail  <= tail + ROB_IDX_W'(acc);
      count <= count + (ROB_IDX_W+1)'(acc)
                     - (ROB_IDX_W+1)'(rob_retire_num);
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (set_complete[i]) ent[i].complete <= 1'b1;
      end
      if (ret0) begin
        ent[head].valid    <= 1'b0;
        ent[head].complete <= 1'b0;
      end
      if (ret1) begin
        ent[head1].valid    <= 1'b0;
        ent[head1].complete <= 1'b0;
      end
      if (acc != 2'd0) begin
        ent[tail] <= '{1'b1, 1'b0, fl_rob_pr0,
                       mt_rob_old_pr0, id_rob_ar0};
      end
      if (acc == 2'd2) begin
        ent[tail1] <= '{1'b1, 1'b0, fl_rob_pr1,
                        mt_rob_old_pr1, id_rob_ar1};
      end
    end
  end
endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob against a queue-based reference model.
// Build with +define+ROB_FLUSH_EN to exercise the flush port.
module tb_rob;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rob_flush = 1'b0;
  logic [1:0] id_dispatch_num = '0;
  logic [6:0] fl_rob_pr0 = '0, fl_rob_pr1 = '0;
  logic [6:0] mt_rob_old_pr0 = '0, mt_rob_old_pr1 = '0;
  logic [4:0] id_rob_ar0 = '0, id_rob_ar1 = '0;
  logic       cdb_valid_0 = 1'b0, cdb_valid_1 = 1'b0;
  logic [6:0] cdb_tag_0 = '0, cdb_tag_1 = '0;
  logic [1:0] rob_free_num, rob_retire_num;
  logic [6:0] rob_retire_tag_0, rob_retire_tag_1;
  logic [6:0] rob_retire_pr_0, rob_retire_pr_1;
  logic [4:0] rob_retire_ar_0, rob_retire_ar_1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] pr;
    logic [6:0] old;
    logic [4:0] ar;
    bit         c;
  } ment_t;

  ment_t q[$];

  always #5 clock = ~clock;

  rob dut (
    .clock           (clock),
    .reset           (reset),
`ifdef ROB_FLUSH_EN
    .rob_flush       (rob_flush),
`endif
    .id_dispatch_num (id_dispatch_num),
    .fl_rob_pr0      (fl_rob_pr0),
    .fl_rob_pr1      (fl_rob_pr1),
    .mt_rob_old_pr0  (mt_rob_old_pr0),
    .mt_rob_old_pr1  (mt_rob_old_pr1),
    .id_rob_ar0      (id_rob_ar0),
    .id_rob_ar1      (id_rob_ar1),
    .cdb_valid_0     (cdb_valid_0),
    .cdb_valid_1     (cdb_valid_1),
    .cdb_tag_0       (cdb_tag_0),
    .cdb_tag_1       (cdb_tag_1),
    .rob_free_num    (rob_free_num),
    .rob_retire_num  (rob_retire_num),
    .rob_retire_tag_0(rob_retire_tag_0),
    .rob_retire_tag_1(rob_retire_tag_1),
    .rob_retire_pr_0 (rob_retire_pr_0),
    .rob_retire_pr_1 (rob_retire_pr_1),
    .rob_retire_ar_0 (rob_retire_ar_0),
    .rob_retire_ar_1 (rob_retire_ar_1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic disp(int n, logic [6:0] p0, logic [6:0] p1,
                      logic [6:0] o0, logic [6:0] o1,
                      logic [4:0] a0, logic [4:0] a1);
    id_dispatch_num = 2'(n);
    fl_rob_pr0 = p0;     fl_rob_pr1 = p1;
    mt_rob_old_pr0 = o0; mt_rob_old_pr1 = o1;
    id_rob_ar0 = a0;     id_rob_ar1 = a1;
  endtask

  task automatic cdb(logic v0, logic [6:0] t0,
                     logic v1, logic [6:0] t1);
    cdb_valid_0 = v0; cdb_tag_0 = t0;
    cdb_valid_1 = v1; cdb_tag_1 = t1;
  endtask

  task automatic idle();
    disp(0, 0, 0, 0, 0, 0, 0);
    cdb(0, 0, 0, 0);
  endtask

  // Check outputs against the model, then advance model and DUT one edge.
  task automatic step();
    int fr, nr, n;
    ment_t e0, e1;
    e0 = '{7'd0, 7'd0, 5'd0, 1'b0};
    e1 = '{7'd0, 7'd0, 5'd0, 1'b0};
    fr = (32 - q.size() >= 2) ? 2 : 32 - q.size();
    nr = 0;
    if (q.size() > 0 && q[0].c) begin
      nr = 1;
      e0 = q[0];
      if (q.size() > 1 && q[1].c) begin
        nr = 2;
        e1 = q[1];
      end
    end
    chk("free_num", rob_free_num, fr);
    chk("retire_num", rob_retire_num, nr);
    chk("retire_tag_0", rob_retire_tag_0, e0.old);
    chk("retire_pr_0", rob_retire_pr_0, e0.pr);
    chk("retire_ar_0", rob_retire_ar_0, e0.ar);
    chk("retire_tag_1", rob_retire_tag_1, e1.old);
    chk("retire_pr_1", rob_retire_pr_1, e1.pr);
    chk("retire_ar_1", rob_retire_ar_1, e1.ar);
    if (reset) begin
      q.delete();
`ifdef ROB_FLUSH_EN
    end else if (rob_flush) begin
      q.delete();
`endif
    end else begin
      repeat (nr) void'(q.pop_front());
      foreach (q[i]) begin
        if ((cdb_valid_0 && q[i].pr == cdb_tag_0) ||
            (cdb_valid_1 && q[i].pr == cdb_tag_1))
          q[i].c = 1'b1;
      end
      n = (id_dispatch_num == 2'd3) ? 2 : int'(id_dispatch_num);
      if (n > fr) n = fr;
      if (n >= 1) q.push_back('{fl_rob_pr0, mt_rob_old_pr0, id_rob_ar0, 1'b0});
      if (n == 2) q.push_back('{fl_rob_pr1, mt_rob_old_pr1, id_rob_ar1, 1'b0});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] t0, t1;
    int k;
    @(posedge clock);
    #1;
    step();
    reset = 1'b0;
    step();
    chk("idle_free", rob_free_num, 2);
    chk("idle_retire", rob_retire_num, 0);

    // Basic: head incomplete blocks retire until its own tag arrives.
    disp(2, 7'd32, 7'd33, 7'd1, 7'd2, 5'd1, 5'd2);
    step();
    idle();
    cdb(1, 7'd33, 0, 0);
    step();
    cdb(1, 7'd32, 0, 0);
    step();
    idle();
    chk("tp_retire_num", rob_retire_num, 2);
    chk("tp_tag_0", rob_retire_tag_0, 1);
    chk("tp_tag_1", rob_retire_tag_1, 2);
    chk("tp_pr_0", rob_retire_pr_0, 32);
    chk("tp_pr_1", rob_retire_pr_1, 33);
    step();
    step();

    // Fill to full, then over-dispatch.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      disp(2, 7'(64 + 2*i), 7'(65 + 2*i), 7'(i), 7'(i + 20),
           5'(i), 5'(i + 1));
      step();
    end
    disp(1, 7'd100, 7'd0, 7'd50, 7'd0, 5'd3, 5'd0);
    step();
    chk("free_31", rob_free_num, 1);
    disp(1, 7'd101, 7'd0, 7'd51, 7'd0, 5'd4, 5'd0);
    step();
    chk("free_full", rob_free_num, 0);
    disp(2, 7'd110, 7'd111, 7'd60, 7'd61, 5'd5, 5'd6);
    step();
    chk("full_stays", rob_free_num, 0);

    // Full with head complete: retire one, accept none.
    idle();
    cdb(1, 7'd64, 0, 0);
    step();
    cdb(0, 0, 0, 0);
    disp(2, 7'd112, 7'd113, 7'd62, 7'd63, 5'd7, 5'd8);
    chk("full_ret1", rob_retire_num, 1);
    step();
    idle();
    chk("full_free1", rob_free_num, 1);
    step();

    // Wrap-around: occupy 30, drain, then dispatch across 31->0->1.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      disp(2, 7'(2*i + 1), 7'(2*i + 2), 7'(90 + i), 7'(70 + i),
           5'(i), 5'(31 - i));
      step();
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      cdb(1, 7'(2*i + 1), 1, 7'(2*i + 2));
      step();
    end
    idle();
    for (int i = 0; i < 16; i++) step();
    chk("wrap_empty_free", rob_free_num, 2);
    disp(2, 7'd40, 7'd41, 7'd11, 7'd12, 5'd9, 5'd10);
    step();
    disp(2, 7'd42, 7'd43, 7'd13, 7'd14, 5'd11, 5'd12);
    step();
    idle();
    cdb(1, 7'd43, 1, 7'd42);
    step();
    cdb(1, 7'd41, 1, 7'd40);
    step();
    idle();
    chk("wrap_ret_num", rob_retire_num, 2);
    chk("wrap_tag_0", rob_retire_tag_0, 11);
    step();
    chk("wrap_tag_1st", rob_retire_tag_0, 13);
    step();

`ifdef ROB_FLUSH_EN
    do_reset();
    disp(2, 7'd20, 7'd21, 7'd5, 7'd6, 5'd1, 5'd2);
    step();
    disp(2, 7'd22, 7'd23, 7'd7, 7'd8, 5'd3, 5'd4);
    step();
    disp(1, 7'd24, 7'd0, 7'd9, 7'd0, 5'd5, 5'd0);
    step();
    idle();
    cdb(1, 7'd20, 1, 7'd21);
    step();
    idle();
    rob_flush = 1'b1;
    chk("flush_ret", rob_retire_num, 2);
    step();
    rob_flush = 1'b0;
    chk("flush_free", rob_free_num, 2);
    chk("flush_noret", rob_retire_num, 0);
    step();
`endif

    // Random traffic with occasional mid-run reset.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      disp($urandom_range(0, 3), 7'($urandom), 7'($urandom),
           7'($urandom), 7'($urandom), 5'($urandom), 5'($urandom));
      t0 = 7'($urandom);
      t1 = 7'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, q.size() - 1);
        t0 = q[k].pr;
      end
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, q.size() - 1);
        t1 = q[k].pr;
      end
      cdb(1'($urandom), t0, 1'($urandom), t1);
      reset = ($urandom_range(0, 99) == 0);
`ifdef ROB_FLUSH_EN
      rob_flush = ($urandom_range(0, 79) == 0);
`endif
      step();
    end
    reset = 1'b0;
    rob_flush = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
